// File: rtl/fft_r22sdf_stage_if.sv
// Sample stream between chained R2^2 SDF stages.
// One bundle per direction; the producer drives it through the master modport.
interface fft_r22sdf_stage_if #(
    parameter int W  = 25,
    parameter int NL = 10
);
    logic                valid;
    logic [NL-1:0]       cnt;
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;

    modport master (output valid, cnt, re, im);
    modport slave  (input  valid, cnt, re, im);
endinterface

// File: rtl/fft_r22sdf_stage.sv
// Radix-2^2 single-path delay-feedback FFT stage: BFI, trivial +/-j
// rotation, BFII, both feedback delay lines and a registered output.
module fft_r22sdf_stage #(
    parameter int DW        = 25,
    parameter int FFT_NLOG2 = 10,
    parameter int STAGE     = 0,
    parameter int SCALE     = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               inv_i,
    fft_r22sdf_stage_if.slave  x_if,
    fft_r22sdf_stage_if.master z_if
);
    localparam int NL = FFT_NLOG2;
    localparam int B1 = NL - 1 - 2 * STAGE;
    localparam int B2 = B1 - 1;
    localparam int N  = 1 << NL;
    localparam int L1 = 1 << B1;
    localparam int L2 = L1 / 2;
    localparam int SH = (SCALE != 0) ? 1 : 0;
    localparam int OW = (SCALE != 0) ? DW : DW + 2;
    localparam int BW = (SCALE != 0) ? DW : DW + 1;
    localparam int RW = BW + 1;

    localparam logic [NL-1:0] PRIME = NL'(L1 + L2);
    localparam logic [NL-1:0] CP0   = NL'(N - L1);

    logic signed [BW-1:0] f1_re [L1];
    logic signed [BW-1:0] f1_im [L1];
    logic signed [RW-1:0] f2_re [L2];
    logic signed [RW-1:0] f2_im [L2];

    logic [NL-1:0] cp;
    logic [NL-1:0] prime;

    logic b1;
    logic b2;
    logic rot_en;

    logic signed [BW-1:0] h1_re, h1_im;
    logic signed [DW:0]   a1_re, a1_im;
    logic signed [DW:0]   d1_re, d1_im;
    logic signed [BW-1:0] y_re, y_im;
    logic signed [BW-1:0] w1_re, w1_im;

    logic signed [RW-1:0] r_re, r_im;
    logic signed [RW-1:0] h2_re, h2_im;
    logic signed [RW-1:0] a2_re, a2_im;
    logic signed [RW-1:0] d2_re, d2_im;
    logic signed [RW-1:0] w2_re, w2_im;
    logic signed [OW-1:0] v_re, v_im;

    // BFI selects on the input index, rotation and BFII on the BFI
    // output index c', which trails the input by L1 samples.
    assign b1     = x_if.cnt[B1];
    assign b2     = cp[B2];
    assign rot_en = cp[B1] & cp[B2];

    always_comb begin
        h1_re = f1_re[L1-1];
        h1_im = f1_im[L1-1];
        a1_re = (DW+1)'(h1_re) + (DW+1)'(x_if.re);
        a1_im = (DW+1)'(h1_im) + (DW+1)'(x_if.im);
        d1_re = (DW+1)'(h1_re) - (DW+1)'(x_if.re);
        d1_im = (DW+1)'(h1_im) - (DW+1)'(x_if.im);
        if (b1) begin
            y_re  = a1_re[BW-1+SH:SH];
            y_im  = a1_im[BW-1+SH:SH];
            w1_re = d1_re[BW-1+SH:SH];
            w1_im = d1_im[BW-1+SH:SH];
        end else begin
            y_re  = h1_re;
            y_im  = h1_im;
            w1_re = BW'(x_if.re);
            w1_im = BW'(x_if.im);
        end
    end

    always_comb begin
        r_re = RW'(y_re);
        r_im = RW'(y_im);
        if (rot_en) begin
            if (inv_i) begin
                r_re = -RW'(y_im);
                r_im = RW'(y_re);
            end else begin
                r_re = RW'(y_im);
                r_im = -RW'(y_re);
            end
        end
    end

    always_comb begin
        h2_re = f2_re[L2-1];
        h2_im = f2_im[L2-1];
        a2_re = h2_re + r_re;
        a2_im = h2_im + r_im;
        d2_re = h2_re - r_re;
        d2_im = h2_im - r_im;
        if (b2) begin
            v_re  = a2_re[OW-1+SH:SH];
            v_im  = a2_im[OW-1+SH:SH];
            w2_re = RW'($signed(d2_re[OW-1+SH:SH]));
            w2_im = RW'($signed(d2_im[OW-1+SH:SH]));
        end else begin
            v_re  = h2_re[OW-1:0];
            v_im  = h2_im[OW-1:0];
            w2_re = r_re;
            w2_im = r_im;
        end
    end

    // Floor scaling simply drops these LSBs.
    logic unused_lsb;
    assign unused_lsb = ^{a1_re[0], a1_im[0], d1_re[0], d1_im[0],
                          a2_re[0], a2_im[0], d2_re[0], d2_im[0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < L1; i++) begin
                f1_re[i] <= '0;
                f1_im[i] <= '0;
            end
            for (int i = 0; i < L2; i++) begin
                f2_re[i] <= '0;
                f2_im[i] <= '0;
            end
        end else if (x_if.valid) begin
            f1_re[0] <= w1_re;
            f1_im[0] <= w1_im;
            for (int i = 1; i < L1; i++) begin
                f1_re[i] <= f1_re[i-1];
                f1_im[i] <= f1_im[i-1];
            end
            f2_re[0] <= w2_re;
            f2_im[0] <= w2_im;
            for (int i = 1; i < L2; i++) begin
                f2_re[i] <= f2_re[i-1];
                f2_im[i] <= f2_im[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cp         <= CP0;
            prime      <= '0;
            z_if.valid <= 1'b0;
            z_if.cnt   <= '0;
            z_if.re    <= '0;
            z_if.im    <= '0;
        end else if (x_if.valid) begin
            cp <= cp + NL'(1);
            if (prime != PRIME) begin
                prime <= prime + NL'(1);
            end
            z_if.valid <= (prime == PRIME);
            z_if.cnt   <= x_if.cnt - PRIME;
            z_if.re    <= v_re;
            z_if.im    <= v_im;
        end else begin
            z_if.valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fft_r22sdf_stage.sv
// Bench for fft_r22sdf_stage (N=16, STAGE=0): SCALE=0 and SCALE=1
// instances share one input stream and are checked against a frame model.
module tb_fft_r22sdf_stage;
    typedef struct {
        int re;
        int im;
        int cnt;
    } smp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic inv = 1'b0;
    always #5 clk = ~clk;

    fft_r22sdf_stage_if #(.W(16), .NL(4)) x_if ();
    fft_r22sdf_stage_if #(.W(18), .NL(4)) z0_if ();
    fft_r22sdf_stage_if #(.W(16), .NL(4)) z1_if ();

    fft_r22sdf_stage #(.DW(16), .FFT_NLOG2(4), .STAGE(0), .SCALE(0)) u0 (
        .clk_i(clk), .rst_i(rst), .inv_i(inv),
        .x_if(x_if), .z_if(z0_if)
    );
    fft_r22sdf_stage #(.DW(16), .FFT_NLOG2(4), .STAGE(0), .SCALE(1)) u1 (
        .clk_i(clk), .rst_i(rst), .inv_i(inv),
        .x_if(x_if), .z_if(z1_if)
    );

    int vectors = 0;
    int miscompares = 0;
    int accepted = 0;
    int first_acc = -1;
    int gap_viol = 0;
    int bad;
    int s_re[$];
    int s_im[$];
    smp_t q0[$];
    smp_t q1[$];
    smp_t e0[$];
    smp_t e1[$];
    logic last_v = 1'b0;
    logic last_rst = 1'b1;
    int p0_re = 0, p0_im = 0, p1_re = 0, p1_im = 0;

    always @(posedge clk) begin
        last_v   <= x_if.valid;
        last_rst <= rst;
    end

    // Capture outputs; also note any valid_o or data change after an idle input cycle.
    always @(negedge clk) begin
        smp_t s;
        if (z0_if.valid === 1'b1) begin
            s.re = int'(z0_if.re); s.im = int'(z0_if.im); s.cnt = int'(z0_if.cnt);
            q0.push_back(s);
            if (first_acc < 0) first_acc = accepted;
        end
        if (z1_if.valid === 1'b1) begin
            s.re = int'(z1_if.re); s.im = int'(z1_if.im); s.cnt = int'(z1_if.cnt);
            q1.push_back(s);
        end
        if (last_v === 1'b0 && last_rst === 1'b0) begin
            if (z0_if.valid !== 1'b0 || z1_if.valid !== 1'b0) gap_viol++;
            if (int'(z0_if.re) != p0_re || int'(z0_if.im) != p0_im) gap_viol++;
            if (int'(z1_if.re) != p1_re || int'(z1_if.im) != p1_im) gap_viol++;
        end
        p0_re = int'(z0_if.re); p0_im = int'(z0_if.im);
        p1_re = int'(z1_if.re); p1_im = int'(z1_if.im);
    end

    // Frame-level reference: BFI pairs c with c+8, -j/+j on c=12..15,
    // BFII pairs c with c+4 inside each half; floor halving per butterfly.
    function automatic void build_expect();
        int yr[16];
        int yi[16];
        int a, b, t, o;
        smp_t s;
        e0.delete();
        e1.delete();
        for (int sc = 0; sc < 2; sc++) begin
            for (int f = 0; f * 16 < s_re.size(); f++) begin
                o = f * 16;
                for (int c = 0; c < 16; c++) begin
                    if (c < 8) begin
                        a = s_re[o+c] + s_re[o+c+8];
                        b = s_im[o+c] + s_im[o+c+8];
                    end else begin
                        a = s_re[o+c-8] - s_re[o+c];
                        b = s_im[o+c-8] - s_im[o+c];
                    end
                    if (sc == 1) begin a = a >>> 1; b = b >>> 1; end
                    if (c >= 12) begin
                        t = a;
                        if (inv) begin a = -b; b = t; end
                        else begin a = b; b = -t; end
                    end
                    yr[c] = a; yi[c] = b;
                end
                for (int c = 0; c < 16; c++) begin
                    if (c % 8 < 4) begin
                        a = yr[c] + yr[c+4]; b = yi[c] + yi[c+4];
                    end else begin
                        a = yr[c-4] - yr[c]; b = yi[c-4] - yi[c];
                    end
                    if (sc == 1) begin a = a >>> 1; b = b >>> 1; end
                    s.re = a; s.im = b; s.cnt = c;
                    if (sc == 0) e0.push_back(s);
                    else e1.push_back(s);
                end
            end
        end
    endfunction

    function automatic int first_bad(input smp_t got[$], input smp_t exp[$]);
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            if (got[i].re != exp[i].re || got[i].im != exp[i].im ||
                got[i].cnt != exp[i].cnt) return i;
        end
        return -1;
    endfunction

    function automatic void add_frame(input int kind, input int idx, input int amp);
        for (int c = 0; c < 16; c++) begin
            case (kind)
                0: begin s_re.push_back(amp); s_im.push_back(0); end
                1: begin s_re.push_back(c == idx ? amp : 0); s_im.push_back(0); end
                default: begin
                    s_re.push_back(int'($urandom_range(16000)) - 8000);
                    s_im.push_back(int'($urandom_range(16000)) - 8000);
                end
            endcase
        end
    endfunction

    task automatic clear_run();
        q0.delete(); q1.delete();
        s_re.delete(); s_im.delete();
        accepted = 0;
        first_acc = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        x_if.valid = 1'b0; x_if.cnt = '0; x_if.re = '0; x_if.im = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_run();
    endtask

    task automatic drive_all(input int gap_pct);
        for (int i = 0; i < s_re.size(); i++) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                x_if.valid = 1'b0;
                repeat ($urandom_range(3, 1)) @(posedge clk);
                #1;
            end
            x_if.valid = 1'b1;
            x_if.cnt = 4'(i % 16);
            x_if.re = 16'(s_re[i]);
            x_if.im = 16'(s_im[i]);
            @(posedge clk);
            accepted++;
            #1;
        end
        x_if.valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (z0_if.valid !== 1'b0 || z1_if.valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid got %b/%b exp 0/0", z0_if.valid, z1_if.valid);
        end
        vectors++;
        if (z0_if.cnt !== 4'd0 || z1_if.cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_cnt got %0d/%0d exp 0", z0_if.cnt, z1_if.cnt);
        end
        vectors++;
        if (z0_if.re !== 18'sd0 || z0_if.im !== 18'sd0 ||
            z1_if.re !== 16'sd0 || z1_if.im !== 16'sd0) begin
            miscompares++;
            $display("FAIL reset_data got %0d %0d %0d %0d exp 0",
                     z0_if.re, z0_if.im, z1_if.re, z1_if.im);
        end
    endtask

    task automatic test_dc();
        do_reset();
        inv = 1'b0;
        add_frame(0, 0, 100); add_frame(0, 0, 100); add_frame(0, 0, 0);
        drive_all(0);
        build_expect();
        vectors++;
        if (first_acc != 13) begin
            miscompares++;
            $display("FAIL dc_prime got %0d exp 13", first_acc);
        end
        vectors++;
        if (q0.size() != e0.size() - 12) begin
            miscompares++;
            $display("FAIL dc_count got %0d exp %0d", q0.size(), e0.size() - 12);
        end
        vectors++;
        if (q0.size() < 1 || q0[0].re != 400 || q0[0].cnt != 0) begin
            miscompares++;
            $display("FAIL dc_k0 got %0d c%0d exp 400 c0",
                     q0.size() > 0 ? q0[0].re : -1, q0.size() > 0 ? q0[0].cnt : -1);
        end
        bad = first_bad(q0, e0);
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL dc_s0 k%0d got %0d,%0d c%0d exp %0d,%0d c%0d", bad,
                     q0[bad].re, q0[bad].im, q0[bad].cnt, e0[bad].re, e0[bad].im, e0[bad].cnt);
        end
    endtask

    task automatic test_impulse(input int idx, input bit inv_sel);
        do_reset();
        inv = inv_sel;
        add_frame(1, idx, 1000); add_frame(1, idx, 1000); add_frame(0, 0, 0);
        drive_all(0);
        build_expect();
        vectors++;
        if (q0.size() != 36) begin
            miscompares++;
            $display("FAIL imp%0d_count got %0d exp 36", idx, q0.size());
        end
        bad = first_bad(q0, e0);
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL imp%0d_inv%0d k%0d got %0d,%0d c%0d exp %0d,%0d c%0d",
                     idx, inv_sel, bad, q0[bad].re, q0[bad].im, q0[bad].cnt,
                     e0[bad].re, e0[bad].im, e0[bad].cnt);
        end
        if (idx == 12 && q0.size() >= 16) begin
            vectors++;
            if (q0[0].re != 1000 || q0[4].re != -1000 || q0[8].re != 0 ||
                q0[8].im != (inv_sel ? -1000 : 1000) ||
                q0[12].im != (inv_sel ? 1000 : -1000)) begin
                miscompares++;
                $display("FAIL imp12_inv%0d_bins got %0d %0d %0d %0d exp 1000 -1000 %0d %0d",
                         inv_sel, q0[0].re, q0[4].re, q0[8].im, q0[12].im,
                         inv_sel ? -1000 : 1000, inv_sel ? 1000 : -1000);
            end
        end
    endtask

    task automatic test_scaling(input int amp, input int exp_bin);
        do_reset();
        inv = 1'b0;
        add_frame(1, 0, amp); add_frame(0, 0, 0);
        drive_all(0);
        build_expect();
        vectors++;
        if (q1.size() < 13 || q1[0].re != exp_bin || q1[4].re != exp_bin ||
            q1[8].re != exp_bin || q1[12].re != exp_bin) begin
            miscompares++;
            $display("FAIL scale_%0d got %0d %0d %0d %0d exp %0d", amp,
                     q1.size() > 12 ? q1[0].re : -1, q1.size() > 12 ? q1[4].re : -1,
                     q1.size() > 12 ? q1[8].re : -1, q1.size() > 12 ? q1[12].re : -1,
                     exp_bin);
        end
        bad = first_bad(q1, e1);
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL scale_%0d_s1 k%0d got %0d,%0d exp %0d,%0d", amp, bad,
                     q1[bad].re, q1[bad].im, e1[bad].re, e1[bad].im);
        end
    endtask

    task automatic test_random(input int gap_pct);
        do_reset();
        inv = 1'($urandom_range(1));
        add_frame(1, int'($urandom_range(15)), 1000);
        add_frame(2, 0, 0); add_frame(2, 0, 0); add_frame(2, 0, 0);
        add_frame(0, 0, 0);
        gap_viol = 0;
        drive_all(gap_pct);
        build_expect();
        vectors++;
        if (q0.size() != accepted - 12 || q1.size() != accepted - 12) begin
            miscompares++;
            $display("FAIL rand_g%0d_count got %0d/%0d exp %0d",
                     gap_pct, q0.size(), q1.size(), accepted - 12);
        end
        bad = first_bad(q0, e0);
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL rand_g%0d_s0 k%0d got %0d,%0d c%0d exp %0d,%0d c%0d", gap_pct, bad,
                     q0[bad].re, q0[bad].im, q0[bad].cnt, e0[bad].re, e0[bad].im, e0[bad].cnt);
        end
        bad = first_bad(q1, e1);
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL rand_g%0d_s1 k%0d got %0d,%0d c%0d exp %0d,%0d c%0d", gap_pct, bad,
                     q1[bad].re, q1[bad].im, q1[bad].cnt, e1[bad].re, e1[bad].im, e1[bad].cnt);
        end
        vectors++;
        if (gap_viol != 0) begin
            miscompares++;
            $display("FAIL rand_g%0d_idle got %0d idle-cycle changes exp 0", gap_pct, gap_viol);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        inv = 1'b0;
        for (int i = 0; i < 22; i++) begin
            x_if.valid = 1'b1;
            x_if.cnt = 4'(i % 16);
            x_if.re = 16'sd100;
            x_if.im = '0;
            if (i == 21) rst = 1'b1;
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        x_if.valid = 1'b0;
        vectors++;
        if (z0_if.valid !== 1'b0 || z0_if.cnt !== 4'd0 ||
            z0_if.re !== 18'sd0 || z0_if.im !== 18'sd0) begin
            miscompares++;
            $display("FAIL midrst_out got v%b c%0d %0d,%0d exp v0 c0 0,0",
                     z0_if.valid, z0_if.cnt, z0_if.re, z0_if.im);
        end
        vectors++;
        if (z1_if.valid !== 1'b0 || z1_if.re !== 16'sd0) begin
            miscompares++;
            $display("FAIL midrst_out1 got v%b %0d exp v0 0", z1_if.valid, z1_if.re);
        end
        clear_run();
        add_frame(0, 0, 100); add_frame(0, 0, 100); add_frame(0, 0, 0);
        drive_all(0);
        build_expect();
        vectors++;
        if (first_acc != 13) begin
            miscompares++;
            $display("FAIL midrst_prime got %0d exp 13", first_acc);
        end
        bad = first_bad(q0, e0);
        vectors++;
        if (bad >= 0 || q0.size() != 36) begin
            miscompares++;
            $display("FAIL midrst_dc k%0d got n=%0d exp n=36", bad, q0.size());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_dc();
        test_impulse(0, 1'b0);
        test_impulse(12, 1'b0);
        test_impulse(12, 1'b1);
        test_scaling(1001, 250);
        test_scaling(-1001, -251);
        for (int r = 0; r < 4; r++) test_random(0);
        for (int r = 0; r < 4; r++) test_random(30);
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
